joy_serial_decoder: RTL and testbench



---
 rtl/joy_serial_decoder.sv | 178 +++++++++++++++++
 tb/tb_joy_serial_decoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_serial_decoder.sv
// Scans NUM_JOYS DB9 ports through a 74HC165 chain, optionally in two Megadrive phases,
// and publishes all button states together once per complete scan.
module joy_serial_decoder #(
    parameter int NUM_JOYS     = 2,
    parameter int CLKDIV       = 14,
    parameter bit MD_ENABLE    = 1'b1,
    parameter int SETTLE_TICKS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  joy_data,
    output logic                  joy_clk,
    output logic                  joy_load_n,
    output logic                  joy_select,
    output logic [NUM_JOYS*8-1:0] joy_state,
    output logic [NUM_JOYS-1:0]   md_present,
    output logic                  scan_done
);

    localparam int CHAIN_BITS = NUM_JOYS * 8;
    localparam int DIV_W      = $clog2(CLKDIV);
    localparam int BIT_W      = $clog2(CHAIN_BITS + 1);
    localparam int SET_W      = $clog2(SETTLE_TICKS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_SETTLE,
        ST_COMMIT
    } state_e;

    state_e                  state_q;
    logic [DIV_W-1:0]        div_q, div_d;
    logic                    tick;
    logic [1:0]              data_sync_q;
    logic                    data_s;
    logic [BIT_W-1:0]        bit_cnt_q;
    logic [SET_W-1:0]        settle_q;
    logic                    phase_q;
    logic [CHAIN_BITS-1:0]   p0_q, p1_q;
    logic                    joy_clk_q, joy_load_n_q, joy_select_q, scan_done_q;
    logic [CHAIN_BITS-1:0]   joy_state_q, state_next;
    logic [NUM_JOYS-1:0]     md_present_q, md_next;
    logic                    unused_bits;

    // NOTE: joy_data is asynchronous to clk; only the second flop is ever sampled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_sync_q <= 2'b11;
        end else begin
            data_sync_q <= {data_sync_q[0], joy_data};
        end
    end
    assign data_s = data_sync_q[1];

    // The prescaler is held at zero through COMMIT so every IDLE lasts a full tick.
    assign tick = (div_q == DIV_W'(CLKDIV - 1));

    always_comb begin
        div_d = div_q + 1'b1;
        if (tick || state_q == ST_COMMIT) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Phase 0 supplies the directions and B/C; phase 1 supplies pad detection and A/START.
    always_comb begin
        state_next = '0;
        md_next    = '0;
        for (int j = 0; j < NUM_JOYS; j++) begin
            md_next[j]             = MD_ENABLE && p1_q[8*j+2] && p1_q[8*j+3];
            state_next[8*j +: 6]   = p0_q[8*j +: 6];
            state_next[8*j+6]      = md_next[j] & p1_q[8*j+4];
            state_next[8*j+7]      = md_next[j] & p1_q[8*j+5];
        end
    end

    always_comb begin
        unused_bits = 1'b0;
        for (int j = 0; j < NUM_JOYS; j++) begin
            unused_bits = unused_bits ^ (^{p0_q[8*j+6 +: 2], p1_q[8*j +: 2], p1_q[8*j+6 +: 2]});
        end
    end

    // NOTE: pin outputs are registered in the FSM so they change on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            settle_q     <= '0;
            phase_q      <= 1'b0;
            p0_q         <= '0;
            p1_q         <= '0;
            joy_clk_q    <= 1'b1;
            joy_load_n_q <= 1'b1;
            joy_select_q <= 1'b1;
            joy_state_q  <= '0;
            md_present_q <= '0;
            scan_done_q  <= 1'b0;
        end else begin
            scan_done_q <= 1'b0;
            if (state_q == ST_COMMIT) begin
                joy_state_q  <= state_next;
                md_present_q <= md_next;
                scan_done_q  <= 1'b1;
                joy_select_q <= 1'b1;
                bit_cnt_q    <= '0;
                state_q      <= ST_IDLE;
            end else if (tick) begin
                unique case (state_q)
                    ST_IDLE: begin
                        phase_q      <= 1'b0;
                        joy_load_n_q <= 1'b0;
                        state_q      <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        joy_load_n_q <= 1'b1;
                        joy_clk_q    <= 1'b0;
                        state_q      <= ST_SHIFT_LO;
                    end
                    ST_SHIFT_LO: begin
                        if (phase_q) begin
                            p1_q <= {~data_s, p1_q[CHAIN_BITS-1:1]};
                        end else begin
                            p0_q <= {~data_s, p0_q[CHAIN_BITS-1:1]};
                        end
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        joy_clk_q <= 1'b1;
                        state_q   <= ST_SHIFT_HI;
                    end
                    ST_SHIFT_HI: begin
                        if (bit_cnt_q < BIT_W'(CHAIN_BITS)) begin
                            joy_clk_q <= 1'b0;
                            state_q   <= ST_SHIFT_LO;
                        end else if (MD_ENABLE && !phase_q) begin
                            joy_select_q <= 1'b0;
                            phase_q      <= 1'b1;
                            bit_cnt_q    <= '0;
                            settle_q     <= '0;
                            state_q      <= ST_SETTLE;
                        end else begin
                            state_q <= ST_COMMIT;
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_q == SET_W'(SETTLE_TICKS - 1)) begin
                            joy_load_n_q <= 1'b0;
                            state_q      <= ST_LOAD;
                        end else begin
                            settle_q <= settle_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign joy_clk    = joy_clk_q;
    assign joy_load_n = joy_load_n_q;
    assign joy_select = joy_select_q;
    assign joy_state  = joy_state_q;
    assign md_present = md_present_q;
    assign scan_done  = scan_done_q;

endmodule

// File: tb/tb_joy_serial_decoder.sv
// Bench for joy_serial_decoder: one Megadrive-mode and one Atari-mode instance, each fed by
// a 74HC165 chain model, checked through per-instance expectation queues.
module tb_joy_serial_decoder;

    localparam int CLKDIV    = 14;
    localparam int MD_PERIOD = (3 + 64 + 4) * CLKDIV + 1;
    localparam int AT_PERIOD = (2 + 32) * CLKDIV + 1;

    localparam logic [15:0] VEC_BTN [4] = '{16'h0000, 16'h2811, 16'hC000, 16'h513C};
    localparam logic [1:0]  VEC_TYP [4] = '{2'b00, 2'b00, 2'b10, 2'b10};

    typedef struct packed {
        logic [15:0] st;
        logic [1:0]  md;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Pin levels of one DB9 port; buttons b = {START,A,C,B,right,left,down,up}, pressed = 1.
    function automatic logic [7:0] pins(input logic [7:0] b, input logic is_md, input logic sel);
        logic [7:0] p;
        if (is_md && !sel) p = {2'b00, b[7], b[6], 2'b11, b[1], b[0]};
        else               p = {2'b00, b[5:0]};
        return ~p;
    endfunction

    // b0/t0 are the buttons seen at the phase-0 load, b1/t1 at the phase-1 load.
    function automatic exp_t predict(input logic [15:0] b0, input logic [1:0] t0,
                                     input logic [15:0] b1, input logic [1:0] t1,
                                     input logic md_en);
        exp_t e;
        logic [7:0] q0, q1;
        e = '0;
        for (int j = 0; j < 2; j++) begin
            q0 = ~pins(b0[8*j +: 8], t0[j], 1'b1);
            q1 = ~pins(b1[8*j +: 8], t1[j], 1'b0);
            e.st[8*j +: 6] = q0[5:0];
            if (md_en && q1[2] && q1[3]) begin
                e.md[j]        = 1'b1;
                e.st[8*j + 6]  = q1[4];
                e.st[8*j + 7]  = q1[5];
            end
        end
        return e;
    endfunction

    logic        md_data, md_jclk, md_load_n, md_sel, md_done;
    logic [15:0] md_state;
    logic [1:0]  md_pres;
    logic        at_data, at_jclk, at_load_n, at_sel, at_done;
    logic [15:0] at_state;
    logic [1:0]  at_pres;

    joy_serial_decoder #(.NUM_JOYS(2), .CLKDIV(CLKDIV), .MD_ENABLE(1'b1), .SETTLE_TICKS(4)) dut_md (
        .clk(clk), .reset(reset), .joy_data(md_data), .joy_clk(md_jclk), .joy_load_n(md_load_n),
        .joy_select(md_sel), .joy_state(md_state), .md_present(md_pres), .scan_done(md_done)
    );

    joy_serial_decoder #(.NUM_JOYS(2), .CLKDIV(CLKDIV), .MD_ENABLE(1'b0), .SETTLE_TICKS(4)) dut_at (
        .clk(clk), .reset(reset), .joy_data(at_data), .joy_clk(at_jclk), .joy_load_n(at_load_n),
        .joy_select(at_sel), .joy_state(at_state), .md_present(at_pres), .scan_done(at_done)
    );

    logic [15:0] md_btn = '0, at_btn = '0;
    logic [1:0]  md_typ = '0, at_typ = '0;
    logic [15:0] md_chain = '1, at_chain = '1;

    always @(posedge md_jclk or negedge md_load_n)
        if (!md_load_n) md_chain <= {pins(md_btn[15:8], md_typ[1], md_sel), pins(md_btn[7:0], md_typ[0], md_sel)};
        else            md_chain <= {1'b1, md_chain[15:1]};
    assign md_data = md_chain[0];

    always @(posedge at_jclk or negedge at_load_n)
        if (!at_load_n) at_chain <= {pins(at_btn[15:8], at_typ[1], at_sel), pins(at_btn[7:0], at_typ[0], at_sel)};
        else            at_chain <= {1'b1, at_chain[15:1]};
    assign at_data = at_chain[0];

    exp_t        q_md[$], q_at[$];
    logic [15:0] md_prev = '0, at_prev = '0;
    logic        md_glitch = 1'b0, at_glitch = 1'b0, at_sel_seen = 1'b0;
    int          md_ref = 0, at_ref = 0;
    logic        md_ref_ok = 1'b0, at_ref_ok = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                md_glitch = 1'b0; at_glitch = 1'b0; at_sel_seen = 1'b0;
                md_ref_ok = 1'b0; at_ref_ok = 1'b0;
            end else begin
                if (md_state !== md_prev && md_done !== 1'b1) md_glitch = 1'b1;
                if (at_state !== at_prev && at_done !== 1'b1) at_glitch = 1'b1;
                if (at_sel !== 1'b1) at_sel_seen = 1'b1;
                if (md_done === 1'b1) begin
                    check("md_hold", 32'(md_glitch), 32'd0);
                    md_glitch = 1'b0;
                    if (md_ref_ok) check("md_period", 32'(cyc - md_ref), 32'(MD_PERIOD));
                    md_ref = cyc; md_ref_ok = 1'b1;
                    if (q_md.size() > 0) begin
                        e = q_md.pop_front();
                        check("md_state", 32'(md_state), 32'(e.st));
                        check("md_present", 32'(md_pres), 32'(e.md));
                    end
                end
                if (at_done === 1'b1) begin
                    check("at_hold", 32'(at_glitch), 32'd0);
                    check("at_select_high", 32'(at_sel_seen), 32'd0);
                    at_glitch = 1'b0; at_sel_seen = 1'b0;
                    if (at_ref_ok) check("at_period", 32'(cyc - at_ref), 32'(AT_PERIOD));
                    at_ref = cyc; at_ref_ok = 1'b1;
                    if (q_at.size() > 0) begin
                        e = q_at.pop_front();
                        check("at_state", 32'(at_state), 32'(e.st));
                        check("at_present", 32'(at_pres), 32'(e.md));
                    end
                end
            end
            md_prev = md_state;
            at_prev = at_state;
        end
    end

    task automatic wait_done(input logic at, output logic found);
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ((at ? at_done : md_done) === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check(at ? "at_scan_wait" : "md_scan_wait", 32'(found), 32'd1);
        #1;
    endtask

    task automatic release_reset();
        reset = 1'b0;
        md_ref = cyc; at_ref = cyc;
        md_ref_ok = 1'b1; at_ref_ok = 1'b1;
        q_md.push_back(predict(md_btn, md_typ, md_btn, md_typ, 1'b1));
        q_at.push_back(predict(at_btn, at_typ, at_btn, at_typ, 1'b0));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic found_md, found_at, found;
        logic prev;
        int   lw, lo_w, hi_w, rises, sel_lo, rises1;

        repeat (4) @(negedge clk);
        #1;
        release_reset();

        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    wait_done(1'b0, found_md);
                    if (i < 4) begin
                        md_btn = VEC_BTN[i]; md_typ = VEC_TYP[i];
                    end else begin
                        md_btn = 16'($urandom); md_typ = 2'($urandom);
                    end
                    q_md.push_back(predict(md_btn, md_typ, md_btn, md_typ, 1'b1));
                end
                wait_done(1'b0, found_md);
                md_btn = 16'h0011; md_typ = 2'b00;
                q_md.push_back(predict(16'h0011, 2'b00, 16'hC00C, 2'b10, 1'b1));
                repeat (10 * CLKDIV) @(negedge clk);
                md_btn = 16'hC00C; md_typ = 2'b10;
                wait_done(1'b0, found_md);
                q_md.push_back(predict(md_btn, md_typ, md_btn, md_typ, 1'b1));
                wait_done(1'b0, found_md);
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    wait_done(1'b1, found_at);
                    if (i < 4) begin
                        at_btn = VEC_BTN[i]; at_typ = VEC_TYP[i];
                    end else begin
                        at_btn = 16'($urandom); at_typ = 2'($urandom);
                    end
                    q_at.push_back(predict(at_btn, at_typ, at_btn, at_typ, 1'b0));
                end
                wait_done(1'b1, found_at);
            end
        join

        wait_done(1'b0, found);
        for (int i = 0; i < 4 * CLKDIV && md_load_n !== 1'b0; i++) @(negedge clk);
        lw = 0;
        while (md_load_n === 1'b0 && lw < 100) begin
            lw++;
            @(negedge clk);
        end
        check("load_n_low_clks", 32'(lw), 32'(CLKDIV));

        lo_w = 0; hi_w = 0; rises = 0; sel_lo = 0; prev = md_jclk;
        for (int i = 0; i < 2000 && md_load_n !== 1'b0; i++) begin
            if (!prev && md_jclk) rises++;
            prev = md_jclk;
            if (md_sel === 1'b0) sel_lo++;
            if (rises == 0 && md_jclk === 1'b0) lo_w++;
            if (rises == 1 && md_jclk === 1'b1) hi_w++;
            @(negedge clk);
        end
        check("joy_clk_low_clks", 32'(lo_w), 32'(CLKDIV));
        check("joy_clk_high_clks", 32'(hi_w), 32'(CLKDIV));
        check("phase0_rises", 32'(rises), 32'd16);
        check("select_low_before_load", 32'(sel_lo), 32'(4 * CLKDIV));

        rises1 = 0; prev = md_jclk;
        for (int i = 0; i < 2000 && md_done !== 1'b1; i++) begin
            if (!prev && md_jclk) rises1++;
            prev = md_jclk;
            @(negedge clk);
        end
        check("phase1_rises", 32'(rises1), 32'd16);

        wait_done(1'b0, found);
        repeat (8 * CLKDIV) @(negedge clk);
        for (int i = 0; i < 2 * CLKDIV && md_jclk !== 1'b0; i++) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_joy_clk", 32'(md_jclk), 32'd1);
        check("rst_joy_load_n", 32'(md_load_n), 32'd1);
        check("rst_joy_select", 32'(md_sel), 32'd1);
        check("rst_joy_state", 32'(md_state), 32'h0000);
        check("rst_md_present", 32'(md_pres), 32'd0);
        check("rst_scan_done", 32'(md_done), 32'd0);
        check("rst_at_state", 32'(at_state), 32'h0000);
        q_md.delete();
        q_at.delete();
        repeat (3) @(negedge clk);
        #1;
        release_reset();
        wait_done(1'b1, found);
        wait_done(1'b0, found);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
